// File: rtl/ifetch.sv
// ifetch
// Instruction fetch unit in front of the IF/ID register. It owns the PC,
// keeps at most one instruction-memory request outstanding, and presents a
// registered (ia, id, fetch_valid) slot to IF/ID. A one-entry skid buffer
// catches a fetch that returns while IF/ID is stalled. A branch redirect
// that arrives with a request still in flight parks the target in
// redirect_pc and drains the stale response before fetching the target.
//
// Ports
//   clock         system clock, all state updates on posedge
//   reset_n       asynchronous active-low reset
//   PipeWriteEn   1 = IF/ID takes ia/id this cycle, 0 = stall
//   BranchTaken   one-cycle redirect pulse (overrides stall)
//   BranchTarget  redirect PC, valid with BranchTaken
//   imem_req      instruction memory request
//   imem_addr     word-aligned request address
//   imem_ack      memory response valid (may come in the request cycle)
//   imem_rdata    instruction word, valid with imem_ack
//   ia            instruction address to IF/ID
//   id            instruction word to IF/ID (NOP_WORD on bubbles)
//   fetch_valid   1 = ia/id is a real instruction, 0 = bubble

module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        PipeWriteEn,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ia,
    output logic [31:0] id,
    output logic        fetch_valid
);

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic        run_q, run_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [31:0] ia_q, ia_d;
    logic [31:0] id_q, id_d;
    logic        valid_q, valid_d;
    logic [31:0] k_addr_q, k_addr_d;
    logic [31:0] k_data_q, k_data_d;
    logic        k_valid_q, k_valid_d;

    logic        ack_taken;
    logic        s_free;
    logic [31:0] branch_pc;

    // run_q keeps the request low during reset and for the first cycle
    // after release, so the first request appears one cycle after reset_n
    // rises. While draining, the stale request must stay up until its ack
    // even though the skid is empty; otherwise a full skid blocks fetching.
    assign imem_req  = run_q && ((state_q == DRAIN) || !k_valid_q);
    assign imem_addr = pc_q;
    assign ia          = ia_q;
    assign id          = id_q;
    assign fetch_valid = valid_q;

    // An ack without a request is not a response and is ignored.
    assign ack_taken = imem_req && imem_ack;
    assign s_free    = !valid_q || PipeWriteEn;
    assign branch_pc = {BranchTarget[31:2], 2'b00};

    always_comb begin
        state_d       = state_q;
        run_d         = 1'b1;
        pc_d          = pc_q;
        redirect_pc_d = redirect_pc_q;
        ia_d          = ia_q;
        id_d          = id_q;
        valid_d       = valid_q;
        k_addr_d      = k_addr_q;
        k_data_d      = k_data_q;
        k_valid_d     = k_valid_q;

        if (BranchTaken) begin
            // Redirect squashes both slots even when IF/ID is stalled.
            // If the in-flight response can be retired now (or nothing is
            // in flight) we jump straight away; otherwise wait for it.
            valid_d   = 1'b0;
            id_d      = NOP_WORD;
            k_valid_d = 1'b0;
            if (!imem_req || ack_taken) begin
                pc_d    = branch_pc;
                state_d = FETCH;
            end else begin
                redirect_pc_d = branch_pc;
                state_d       = DRAIN;
            end
        end else if (state_q == DRAIN) begin
            valid_d = 1'b0;
            id_d    = NOP_WORD;
            if (ack_taken) begin
                pc_d    = redirect_pc_q;
                state_d = FETCH;
            end
        end else begin
            if (ack_taken) begin
                pc_d = pc_q + 32'd4;
                if (s_free) begin
                    ia_d    = pc_q;
                    id_d    = imem_rdata;
                    valid_d = 1'b1;
                end else begin
                    k_addr_d  = pc_q;
                    k_data_d  = imem_rdata;
                    k_valid_d = 1'b1;
                end
            end else if (s_free) begin
                // The request is low whenever the skid holds something,
                // so an ack and a full skid never meet here.
                if (k_valid_q) begin
                    ia_d      = k_addr_q;
                    id_d      = k_data_q;
                    valid_d   = 1'b1;
                    k_valid_d = 1'b0;
                end else begin
                    valid_d = 1'b0;
                    id_d    = NOP_WORD;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= FETCH;
            run_q         <= 1'b0;
            pc_q          <= RESET_PC;
            redirect_pc_q <= RESET_PC;
            ia_q          <= 32'h0000_0000;
            id_q          <= NOP_WORD;
            valid_q       <= 1'b0;
            k_addr_q      <= 32'h0000_0000;
            k_data_q      <= 32'h0000_0000;
            k_valid_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            run_q         <= run_d;
            pc_q          <= pc_d;
            redirect_pc_q <= redirect_pc_d;
            ia_q          <= ia_d;
            id_q          <= id_d;
            valid_q       <= valid_d;
            k_addr_q      <= k_addr_d;
            k_data_q      <= k_data_d;
            k_valid_q     <= k_valid_d;
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch
// Bench for ifetch. A memory responder with programmable ack latency
// answers the DUT's requests; a queue-based model of the fetch unit
// predicts ia/id/fetch_valid/imem_req/imem_addr every cycle, and a few
// hand-computed literals pin the model at known points.

module tb_ifetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam logic [31:0] DATA_KEY = 32'hDEAD_0000;

    logic        clock;
    logic        reset_n;
    logic        PipeWriteEn;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ia;
    logic [31:0] id;
    logic        fetch_valid;

    ifetch #(
        .RESET_PC(RESET_PC),
        .NOP_WORD(NOP_WORD)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .PipeWriteEn (PipeWriteEn),
        .BranchTaken (BranchTaken),
        .BranchTarget(BranchTarget),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .ia          (ia),
        .id          (id),
        .fetch_valid (fetch_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Memory responder state
    int mem_lat  = 0;
    int mem_wait = 0;
    bit stray_ack = 1'b0;

    // Model: m_q holds every fetched-but-unconsumed instruction, oldest
    // first; when m_valid the head is what IF/ID sees. At most two fit.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } instr_t;

    instr_t      m_q[$];
    bit          m_valid;
    logic [31:0] m_ia;
    logic [31:0] m_pc;
    logic [31:0] m_redir;
    bit          m_drain;
    bit          m_run;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ DATA_KEY;
    endfunction

    function automatic bit model_req();
        return m_run && (m_drain || (m_q.size() < 2));
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_valid = 1'b0;
        m_ia    = 32'h0000_0000;
        m_pc    = RESET_PC;
        m_redir = RESET_PC;
        m_drain = 1'b0;
        m_run   = 1'b0;
    endtask

    task automatic check_output();
        logic [31:0] exp_id;
        exp_id = NOP_WORD;
        if (m_valid && m_q.size() > 0) exp_id = m_q[0].data;
        check32("fetch_valid", {31'd0, fetch_valid}, {31'd0, m_valid});
        check32("ia", ia, m_ia);
        check32("id", id, exp_id);
        check32("imem_req", {31'd0, imem_req}, {31'd0, model_req()});
        check32("imem_addr", imem_addr, m_pc);
    endtask

    // One clock cycle: drive inputs, let the edge happen, advance the
    // model, then compare a little after the edge.
    task automatic apply_stimulus(input bit pwe, input bit br, input logic [31:0] tgt);
        bit          ack;
        bit          req_seen;
        bit          req_m;
        bit          took;
        logic [31:0] tgt_al;
        instr_t      e;

        req_seen = (imem_req === 1'b1);
        ack      = req_seen && (mem_wait >= mem_lat);
        if (stray_ack) ack = 1'b1;
        PipeWriteEn  = pwe;
        BranchTaken  = br;
        BranchTarget = tgt;
        imem_ack     = ack;
        imem_rdata   = ack ? mem_word(imem_addr) : 32'hBAD0_BAD0;

        req_m  = model_req();
        took   = req_m && ack;
        tgt_al = {tgt[31:2], 2'b00};

        @(posedge clock);

        if (req_seen && !ack) mem_wait++;
        else if (ack) mem_wait = 0;

        if (br) begin
            m_q.delete();
            m_valid = 1'b0;
            if (!req_m || took) begin
                m_pc    = tgt_al;
                m_drain = 1'b0;
            end else begin
                m_redir = tgt_al;
                m_drain = 1'b1;
            end
        end else if (m_drain) begin
            if (took) begin
                m_pc    = m_redir;
                m_drain = 1'b0;
            end
        end else begin
            if (m_valid && pwe) void'(m_q.pop_front());
            if (took) begin
                e.addr = m_pc;
                e.data = mem_word(m_pc);
                m_q.push_back(e);
                m_pc = m_pc + 32'd4;
            end
            if (m_q.size() > 0) begin
                m_valid = 1'b1;
                m_ia    = m_q[0].addr;
            end else begin
                m_valid = 1'b0;
            end
        end
        m_run = 1'b1;

        #1;
        check_output();
    endtask

    // Asserts reset mid-cycle (asynchronously), checks the outputs return
    // to reset values at once, holds for two edges, then releases.
    task automatic do_reset();
        #2;
        reset_n     = 1'b0;
        BranchTaken = 1'b0;
        PipeWriteEn = 1'b1;
        imem_ack    = 1'b0;
        stray_ack   = 1'b0;
        model_reset();
        #1;
        check32("rst imem_req", {31'd0, imem_req}, 32'd0);
        check32("rst imem_addr", imem_addr, 32'h0000_0100);
        check32("rst ia", ia, 32'h0000_0000);
        check32("rst id", id, 32'h0000_0000);
        check32("rst fetch_valid", {31'd0, fetch_valid}, 32'd0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n  = 1'b1;
        mem_wait = 0;
    endtask

    initial begin
        reset_n      = 1'b0;
        PipeWriteEn  = 1'b1;
        BranchTaken  = 1'b0;
        BranchTarget = 32'h0;
        imem_ack     = 1'b0;
        imem_rdata   = 32'h0;
        model_reset();
        @(posedge clock);
        #1;

        // Zero-wait streaming from reset
        do_reset();
        mem_lat = 0;
        apply_stimulus(1'b1, 1'b0, 32'h0);
        check32("lit first req", {31'd0, imem_req}, 32'd1);
        check32("lit first addr", imem_addr, 32'h0000_0100);
        apply_stimulus(1'b1, 1'b0, 32'h0);
        check32("lit ia0", ia, 32'h0000_0100);
        check32("lit id0", id, 32'hDEAD_0100);
        check32("lit valid0", {31'd0, fetch_valid}, 32'd1);
        apply_stimulus(1'b1, 1'b0, 32'h0);
        check32("lit ia1", ia, 32'h0000_0104);
        apply_stimulus(1'b1, 1'b0, 32'h0);
        check32("lit ia2", ia, 32'h0000_0108);

        // Two-cycle memory latency: valid, bubble, bubble
        mem_lat = 2;
        repeat (9) apply_stimulus(1'b1, 1'b0, 32'h0);
        mem_lat = 0;
        repeat (2) apply_stimulus(1'b1, 1'b0, 32'h0);

        // Stall while an ack lands in the skid; stray ack is ignored
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check32("lit stall req low", {31'd0, imem_req}, 32'd0);
        stray_ack = 1'b1;
        apply_stimulus(1'b0, 1'b0, 32'h0);
        stray_ack = 1'b0;
        apply_stimulus(1'b0, 1'b0, 32'h0);
        apply_stimulus(1'b1, 1'b0, 32'h0);
        apply_stimulus(1'b1, 1'b0, 32'h0);

        // Redirect coincident with an ack during a stall
        apply_stimulus(1'b0, 1'b1, 32'h0000_0400);
        check32("lit br valid", {31'd0, fetch_valid}, 32'd0);
        check32("lit br addr", imem_addr, 32'h0000_0400);
        check32("lit br req", {31'd0, imem_req}, 32'd1);
        apply_stimulus(1'b1, 1'b0, 32'h0);
        check32("lit br ia", ia, 32'h0000_0400);
        check32("lit br id", id, 32'hDEAD_0400);

        // PC wrap
        apply_stimulus(1'b1, 1'b1, 32'hFFFF_FFFC);
        apply_stimulus(1'b1, 1'b0, 32'h0);
        check32("lit wrap ia", ia, 32'hFFFF_FFFC);
        check32("lit wrap addr", imem_addr, 32'h0000_0000);

        // Redirects while a slow request to 0x108 is in flight
        do_reset();
        apply_stimulus(1'b1, 1'b0, 32'h0);
        apply_stimulus(1'b1, 1'b0, 32'h0);
        apply_stimulus(1'b1, 1'b0, 32'h0);
        mem_lat = 3;
        apply_stimulus(1'b1, 1'b0, 32'h0);
        check32("lit slow addr", imem_addr, 32'h0000_0108);
        apply_stimulus(1'b1, 1'b1, 32'h0000_0400);
        check32("lit drain addr a", imem_addr, 32'h0000_0108);
        check32("lit drain req", {31'd0, imem_req}, 32'd1);
        check32("lit drain valid", {31'd0, fetch_valid}, 32'd0);
        apply_stimulus(1'b1, 1'b1, 32'h0000_0800);
        check32("lit drain addr b", imem_addr, 32'h0000_0108);
        apply_stimulus(1'b1, 1'b0, 32'h0);
        check32("lit post drain addr", imem_addr, 32'h0000_0800);
        check32("lit post drain valid", {31'd0, fetch_valid}, 32'd0);
        mem_lat = 0;
        apply_stimulus(1'b1, 1'b0, 32'h0);
        check32("lit target ia", ia, 32'h0000_0800);

        // Reset mid-request and mid-stall, then restart
        apply_stimulus(1'b1, 1'b0, 32'h0);
        check32("lit ia 804", ia, 32'h0000_0804);
        mem_lat = 5;
        apply_stimulus(1'b0, 1'b0, 32'h0);
        apply_stimulus(1'b0, 1'b0, 32'h0);
        check32("lit stalled ia", ia, 32'h0000_0804);
        do_reset();
        mem_lat = 0;
        apply_stimulus(1'b1, 1'b0, 32'h0);
        apply_stimulus(1'b1, 1'b0, 32'h0);
        check32("lit restart ia", ia, 32'h0000_0100);
        check32("lit restart valid", {31'd0, fetch_valid}, 32'd1);

        // Mixed stalls, redirects and latencies
        for (int i = 0; i < 80; i++) begin
            logic [31:0] t;
            bit pwe;
            bit br;
            t       = $urandom;
            t[1:0]  = 2'b00;
            pwe     = ($urandom_range(0, 3) != 0);
            br      = ($urandom_range(0, 11) == 0);
            mem_lat = $urandom_range(0, 2);
            apply_stimulus(pwe, br, t);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
